// File: rtl/uart_pkg.sv
// Shared definitions for the byte-output UART transmitter: FSM states and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS           = 10;
  // 100 MHz board clock at 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/byte_uart_tx_if.sv
// Byte-strobe input and UART/status outputs between the SoC output port and the transmitter.
interface byte_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();

  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]        in_byte;
  logic              in_byte_en;
  logic              uart_tx;
  logic              busy;
  logic [CountW-1:0] fifo_count;
  logic              fifo_full;
  logic              overflow;

  modport master (
    output in_byte,
    output in_byte_en,
    input  uart_tx,
    input  busy,
    input  fifo_count,
    input  fifo_full,
    input  overflow
  );

  modport slave (
    input  in_byte,
    input  in_byte_en,
    output uart_tx,
    output busy,
    output fifo_count,
    output fifo_full,
    output overflow
  );

endinterface

// File: rtl/sync_byte_fifo.sv
// Synchronous first-word fall-through FIFO with a separate occupancy counter.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH + 1)-1:0]   count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_push;
  logic              w_pop;
  logic [CountW-1:0] w_count_d;

  // A full FIFO refuses a push even if the same edge pops.
  assign w_push    = push & ~r_full;
  assign w_pop     = pop & ~r_empty;
  assign w_count_d = r_count + CountW'(w_push) - CountW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == CountW'(DEPTH));
      r_empty <= (w_count_d == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/byte_uart_tx.sv
// Buffers byte strobes from the SoC output port and serialises them as 8N1 UART frames.
module byte_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input logic           clk,
  input logic           resetn,
  byte_uart_tx_if.slave bus
);

  localparam int unsigned CountW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BitLast  = 3'(DATA_BITS - 1);

  uart_state_e       r_state,   w_state_d;
  logic [15:0]       r_baud,    w_baud_d;
  logic [2:0]        r_bit_idx, w_bit_idx_d;
  logic [7:0]        r_shift,   w_shift_d;
  logic              r_tx,      w_tx_d;
  logic              r_busy,    w_busy_d;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_baud_last;
  logic [7:0]        w_fifo_dout;
  logic              w_fifo_empty;
  logic [CountW-1:0] w_count_next;

  assign w_push = bus.in_byte_en & ~bus.fifo_full;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (bus.in_byte),
    .dout   (w_fifo_dout),
    .count  (bus.fifo_count),
    .full   (bus.fifo_full),
    .empty  (w_fifo_empty)
  );

  assign w_baud_last = (r_baud == BaudLast);

  always_comb begin
    w_state_d   = r_state;
    w_baud_d    = r_baud;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_tx_d      = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      StIdle: begin
        w_tx_d = 1'b1;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_d   = w_fifo_dout;
          w_baud_d    = '0;
          w_bit_idx_d = '0;
          w_state_d   = StStart;
          w_tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_state_d = StData;
          w_tx_d    = r_shift[0];
        end else begin
          w_baud_d = r_baud + 16'd1;
        end
      end
      StData: begin
        if (w_baud_last) begin
          w_baud_d = '0;
          if (r_bit_idx == BitLast) begin
            w_state_d = StStop;
            w_tx_d    = 1'b1;
          end else begin
            // Next bit is shift[1]; shifting keeps the current bit at shift[0].
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_bit_idx_d = r_bit_idx + 3'd1;
            w_tx_d      = r_shift[1];
          end
        end else begin
          w_baud_d = r_baud + 16'd1;
        end
      end
      StStop: begin
        if (w_baud_last) begin
          w_baud_d = '0;
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_d   = w_fifo_dout;
            w_bit_idx_d = '0;
            w_state_d   = StStart;
            w_tx_d      = 1'b0;
          end else begin
            w_state_d = StIdle;
            w_tx_d    = 1'b1;
          end
        end else begin
          w_baud_d = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
      end
    endcase

    w_count_next = bus.fifo_count + CountW'(w_push) - CountW'(w_pop);
    w_busy_d     = (w_state_d != StIdle) || (w_count_next != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_baud     <= w_baud_d;
      r_bit_idx  <= w_bit_idx_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
      r_busy     <= w_busy_d;
      r_overflow <= r_overflow | (bus.in_byte_en & bus.fifo_full);
    end
  end

  assign bus.uart_tx  = r_tx;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_byte_uart_tx.sv
// Self-checking bench for byte_uart_tx: frame-timer reference model, line decoder, directed table.
module tb_byte_uart_tx;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  byte_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  byte_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t is the cycle index inside the current frame (-1 when the line is idle).
  int         m_t;
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur;
  logic       m_ovf;

  task automatic model_reset();
    m_t = -1;
    m_q.delete();
    m_ovf = 1'b0;
    m_cur = 8'h00;
  endtask

  task automatic model_step(input logic en, input logic [7:0] b);
    int sz;
    sz = m_q.size();
    if (m_t >= 0) begin
      m_t++;
      if (m_t == FRAME_CYC) m_t = -1;
    end
    if (m_t < 0 && sz > 0) begin
      m_cur = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_t = 0;
    end
    if (en) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(b);
    end
  endtask

  function automatic logic m_tx();
    int idx;
    if (m_t < 0) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  int peak;
  bit full_seen;

  task automatic check_all();
    chk("uart_tx",    32'(bus.uart_tx),    32'(m_tx()));
    chk("busy",       32'(bus.busy),       32'((m_t >= 0) || (m_q.size() > 0)));
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    chk("fifo_full",  32'(bus.fifo_full),  32'(m_q.size() == DEPTH));
    chk("overflow",   32'(bus.overflow),   32'(m_ovf));
    if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    if (bus.fifo_full) full_seen = 1'b1;
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic en, input logic [7:0] b);
    bus.in_byte_en = en;
    bus.in_byte    = b;
    @(posedge clk);
    model_step(en, b);
    @(negedge clk);
    bus.in_byte_en = 1'b0;
    check_all();
  endtask

  // Independent line decoder sampling mid-bit.
  logic [7:0] rx_q[$];
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_bits;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rx_act = 1'b0;
      end else begin
        if (!rx_act) begin
          if (bus.uart_tx === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
          end
        end else begin
          rx_cnt++;
        end
        if (rx_act && (rx_cnt % CPB) == CPB / 2) begin
          rx_bits[rx_cnt / CPB] = bus.uart_tx;
          if (rx_cnt / CPB == 9) begin
            chk("rx_start_bit", 32'(rx_bits[0]), 32'd0);
            chk("rx_stop_bit",  32'(rx_bits[9]), 32'd1);
            rx_q.push_back(rx_bits[8:1]);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rx_q.delete();
    m_sent.delete();
    peak      = 0;
    full_seen = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.busy || rx_act) && n < 2000) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
    repeat (4) cycle(1'b0, 8'h00);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [6];
    int         exp_frames;
    logic       exp_ovf;
    int         exp_peak;
    logic       exp_full;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit dense;
    bus.in_byte    = 8'h00;
    bus.in_byte_en = 1'b0;
    model_reset();
    peak      = 0;
    full_seen = 1'b0;

    vecs[0] = '{n: 1, b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_frames: 1, exp_ovf: 1'b0, exp_peak: 1, exp_full: 1'b0};
    vecs[1] = '{n: 3, b: '{8'h48, 8'h69, 8'h21, 8'h00, 8'h00, 8'h00},
                exp_frames: 3, exp_ovf: 1'b0, exp_peak: 2, exp_full: 1'b0};
    vecs[2] = '{n: 6, b: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66},
                exp_frames: 5, exp_ovf: 1'b1, exp_peak: 4, exp_full: 1'b1};

    // Reset values while held in reset.
    @(negedge clk);
    chk("rst_uart_tx",    32'(bus.uart_tx),    32'd1);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_fifo_full",  32'(bus.fifo_full),  32'd0);
    chk("rst_overflow",   32'(bus.overflow),   32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Idle line after reset.
    repeat (100) cycle(1'b0, 8'h00);

    // Two-edge latency from strobe to start bit.
    do_reset();
    cycle(1'b1, 8'hA5);
    chk("lat_tx_after_e0",    32'(bus.uart_tx),    32'd1);
    chk("lat_count_after_e0", 32'(bus.fifo_count), 32'd1);
    cycle(1'b0, 8'h00);
    chk("lat_tx_after_e1",    32'(bus.uart_tx),    32'd0);
    chk("lat_count_after_e1", 32'(bus.fifo_count), 32'd0);
    chk("lat_busy_after_e1",  32'(bus.busy),       32'd1);
    drain();
    chk("lat_busy_end", 32'(bus.busy), 32'd0);

    // Directed scenarios.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) cycle(1'b1, vecs[v].b[i]);
      drain();
      chk($sformatf("vec%0d_frames", v), 32'(rx_q.size()), 32'(vecs[v].exp_frames));
      for (int i = 0; i < vecs[v].exp_frames && i < rx_q.size(); i++)
        chk($sformatf("vec%0d_byte%0d", v, i), 32'(rx_q[i]), 32'(vecs[v].b[i]));
      chk($sformatf("vec%0d_overflow", v), 32'(bus.overflow), 32'(vecs[v].exp_ovf));
      chk($sformatf("vec%0d_peak", v), 32'(peak), 32'(vecs[v].exp_peak));
      chk($sformatf("vec%0d_full_seen", v), 32'(full_seen), 32'(vecs[v].exp_full));
    end

    // Strobe while full, exactly at the STOP->START pop edge.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i));
    n = 0;
    while (!(m_t == FRAME_CYC - 1 && m_q.size() == DEPTH) && n < 200) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("popedge_reached", 32'(n < 200), 32'd1);
    chk("popedge_pre_count", 32'(bus.fifo_count), 32'(DEPTH));
    chk("popedge_pre_ovf",   32'(bus.overflow),   32'd0);
    cycle(1'b1, 8'hEE);
    chk("popedge_count", 32'(bus.fifo_count), 32'(DEPTH - 1));
    chk("popedge_ovf",   32'(bus.overflow),   32'd1);
    chk("popedge_tx",    32'(bus.uart_tx),    32'd0);
    drain();
    chk("popedge_frames", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("popedge_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));

    // Reset during data bit 3 of 0xFF.
    do_reset();
    cycle(1'b1, 8'hFF);
    n = 0;
    while (m_t != CPB + 3 * CPB + 1 && n < 100) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("midreset_reached", 32'(n < 100), 32'd1);
    chk("midreset_pre_tx", 32'(bus.uart_tx), 32'd1);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("midreset_tx",    32'(bus.uart_tx),    32'd1);
    chk("midreset_busy",  32'(bus.busy),       32'd0);
    chk("midreset_count", 32'(bus.fifo_count), 32'd0);
    chk("midreset_ovf",   32'(bus.overflow),   32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rx_q.delete();
    repeat (60) cycle(1'b0, 8'h00);
    chk("midreset_no_frame", 32'(rx_q.size()), 32'd0);

    // Randomised traffic with alternating dense and sparse bursts.
    do_reset();
    dense = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) dense = ($urandom_range(0, 1) == 1);
      cycle(dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
            8'($urandom_range(0, 255)));
    end
    drain();
    chk("rand_frames", 32'(rx_q.size()), 32'(m_sent.size()));
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
      chk($sformatf("rand_byte%0d", i), 32'(rx_q[i]), 32'(m_sent[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_uart_tx.md
Name: byte_uart_tx

Overview:
- Downstream consumer of the SoC's memory-mapped byte-output port: each one-cycle `in_byte_en` strobe delivers one byte (firmware writes to 0x1000_0000).
- Buffers bytes in a small synchronous FIFO and serialises them onto a UART TX line: 8N1, LSB first, fixed baud.
- Lets firmware console output reach a host terminal without stalling the core.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_byte  input  8  byte from the SoC output port.
- in_byte_en  input  1  one-cycle write strobe; `in_byte` is valid in the same cycle.
- uart_tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes buffered.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- overflow  output  1  sticky; set when a strobe is dropped.

Behaviour:
- Reset values: all outputs registered. Asserting resetn low immediately forces:
  - uart_tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0;
  - FSM to IDLE, FIFO pointers to 0.
  - A reset mid-frame truncates the frame; the line returns high immediately.
- Push:
  - On an edge with in_byte_en=1 and fifo_count<FIFO_DEPTH, in_byte is written at the write pointer.
  - If the FIFO is full at that edge, the byte is dropped and overflow is set. This holds even when a pop occurs at the same edge; pushes never use same-cycle freed space.
  - overflow clears only on reset.
- Pop: the FSM removes the FIFO head at the edge it loads the shift register.
- Simultaneous push and pop (FIFO not full): both take effect and fifo_count is unchanged.
- Pointers: wrap modulo FIFO_DEPTH. fifo_count is a separate counter, so full and empty are unambiguous.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If fifo_count>0 at an edge: pop head into the 8-bit shift register, clear the baud counter and bit index, go to START (uart_tx=0 from this edge).
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with uart_tx=shift[0].
  - DATA: each bit holds for CLKS_PER_BIT cycles. The shift register shifts right and the bit index increments 0..7. After bit 7 completes, go to STOP with uart_tx=1.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end:
    - if fifo_count>0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles, measured from the falling edge of the start bit to the end of the stop bit.
- Latency: strobe sampled at edge E0 → count=1 after E0 → pop at E1 → uart_tx falls after E1. For an idle block with an empty FIFO this is 2 edges.
- Baud counter: 16-bit counter counting 0..CLKS_PER_BIT-1. Terminal count advances the bit. Arithmetic wraps to 0 and never overflows.
- busy = (state != IDLE) || (fifo_count != 0), registered from next-state values, so it follows the same timing as fifo_count.
- Bytes are transmitted strictly in arrival order. No data corruption on pointer wrap.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum: IDLE/START/DATA/STOP;
  - UART frame constants: DATA_BITS=8, FRAME_BITS=10;
  - default CLKS_PER_BIT for the 100 MHz board clock.
- Sub-module `sync_byte_fifo`:
  - parameters: DEPTH, WIDTH=8;
  - ports: push/pop/din/dout/count/full/empty;
  - first-word fall-through read; register-array storage.
- The top level holds the FSM, the baud counter, the shift register and the overflow flag.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset then idle 100 cycles → uart_tx stays 1; busy=0; fifo_count=0; overflow=0.
2. Single strobe 0xA5 → uart_tx falls 2 edges later; bits over 40 cycles read 0,1,0,1,0,0,1,0,1,1 (each bit 4 cycles); then busy=0.
3. Strobes 0x48,0x69,0x21 on consecutive cycles → three back-to-back frames (120 cycles, no idle gap); decoded 0x48,0x69,0x21; fifo_count peaks at 2 (the first byte is popped immediately).
4. Six strobes back-to-back while idle → first byte popped, next four buffered, sixth dropped; fifo_full=1; overflow=1 and stays 1; 5 frames transmitted.
5. Strobe while full and exactly at the STOP→START pop edge → byte dropped and overflow set; fifo_count decrements by 1.
6. resetn low during DATA bit 3 of 0xFF, held 3 cycles → uart_tx=1 immediately; FIFO empty; after release no partial frame resumes and the line stays idle.
